// File: rtl/classifier_head_if.sv
// Handshake and result bundle between the PE-array output stage and its producer/consumer.
interface classifier_head_if #(
    parameter int PE_OUT_WIDTH   = 24,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 32,
    parameter int OUTPUT_CHANNEL = 10,
    parameter int IDX_W          = $clog2(OUTPUT_CHANNEL)
);
    logic                                   start;
    logic [OUTPUT_CHANNEL*DATA_WIDTH-1:0]   bias_data;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [OUTPUT_CHANNEL*PE_OUT_WIDTH-1:0] in_data;
    logic                                   busy;
    logic                                   done;
    logic [IDX_W-1:0]                       number;
    logic signed [ACC_WIDTH-1:0]            max_val;

    modport master (
        output start, bias_data, in_valid, in_data,
        input  in_ready, busy, done, number, max_val
    );

    modport slave (
        input  start, bias_data, in_valid, in_data,
        output in_ready, busy, done, number, max_val
    );
endinterface

// File: rtl/classifier_head.sv
// Output stage: accumulates per-class partial sums over all input chunks, adds bias,
// then scans sequentially for the highest score (lowest index wins ties).
module classifier_head #(
    parameter int PE_OUT_WIDTH   = 24,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 32,
    parameter int ARRAY_N        = 16,
    parameter int INP_CHANNEL    = 96,
    parameter int OUTPUT_CHANNEL = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    classifier_head_if.slave  bus
);
    localparam int NUM_CHUNKS = INP_CHANNEL / ARRAY_N;
    localparam int IDX_W      = $clog2(OUTPUT_CHANNEL);
    localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_BIAS  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH:0] sum;
        sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            sat_add = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = sum[ACC_WIDTH-1:0];
        end
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] ext_pe(input logic [PE_OUT_WIDTH-1:0] v);
        ext_pe = {{(ACC_WIDTH-PE_OUT_WIDTH){v[PE_OUT_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] ext_bias(input logic [DATA_WIDTH-1:0] v);
        ext_bias = {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    state_t                       state_r;
    logic signed [ACC_WIDTH-1:0]  acc_r      [OUTPUT_CHANNEL];
    logic [DATA_WIDTH-1:0]        bias_r     [OUTPUT_CHANNEL];
    logic signed [ACC_WIDTH-1:0]  acc_in_s   [OUTPUT_CHANNEL];
    logic signed [ACC_WIDTH-1:0]  acc_bias_s [OUTPUT_CHANNEL];
    logic signed [ACC_WIDTH-1:0]  scan_val_s;
    logic signed [ACC_WIDTH-1:0]  best_r;
    logic [IDX_W-1:0]             best_idx_r;
    logic [IDX_W-1:0]             scan_idx_r;
    logic [CNT_W-1:0]             beat_cnt_r;
    logic                         in_ready_r;
    logic                         busy_r;
    logic                         done_r;
    logic [IDX_W-1:0]             number_r;
    logic signed [ACC_WIDTH-1:0]  max_val_r;

    assign bus.in_ready = in_ready_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.number   = number_r;
    assign bus.max_val  = max_val_r;

    // Saturating per-lane sums for the beat and bias steps, and the current scan candidate.
    always_comb begin
        scan_val_s = acc_r[scan_idx_r];
        for (int k = 0; k < OUTPUT_CHANNEL; k++) begin
            acc_in_s[k]   = sat_add(acc_r[k], ext_pe(bus.in_data[k*PE_OUT_WIDTH +: PE_OUT_WIDTH]));
            acc_bias_s[k] = sat_add(acc_r[k], ext_bias(bias_r[k]));
        end
    end

    // Classification sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            for (int k = 0; k < OUTPUT_CHANNEL; k++) begin
                acc_r[k]  <= '0;
                bias_r[k] <= '0;
            end
            best_r     <= '0;
            best_idx_r <= '0;
            scan_idx_r <= '0;
            beat_cnt_r <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            number_r   <= '0;
            max_val_r  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < OUTPUT_CHANNEL; k++) begin
                            acc_r[k]  <= '0;
                            bias_r[k] <= bus.bias_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        beat_cnt_r <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_ACCUM;
                    end else begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < OUTPUT_CHANNEL; k++) begin
                            acc_r[k] <= acc_in_s[k];
                        end
                        if (beat_cnt_r == CNT_W'(NUM_CHUNKS - 1)) begin
                            beat_cnt_r <= '0;
                            in_ready_r <= 1'b0;
                            state_r    <= ST_BIAS;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_BIAS: begin
                    for (int k = 0; k < OUTPUT_CHANNEL; k++) begin
                        acc_r[k] <= acc_bias_s[k];
                    end
                    best_r     <= acc_bias_s[0];
                    best_idx_r <= '0;
                    scan_idx_r <= IDX_W'(1);
                    state_r    <= ST_SCAN;
                end
                ST_SCAN: begin
                    // Strict compare keeps the earlier index on ties.
                    if (scan_val_s > best_r) begin
                        best_r     <= scan_val_s;
                        best_idx_r <= scan_idx_r;
                    end
                    if (scan_idx_r == IDX_W'(OUTPUT_CHANNEL - 1)) begin
                        state_r <= ST_DONE;
                    end else begin
                        scan_idx_r <= scan_idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done_r    <= 1'b1;
                    number_r  <= best_idx_r;
                    max_val_r <= best_r;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_classifier_head.sv
// Bench for classifier_head: two instances (32-bit and 25-bit accumulators) share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_classifier_head;
    localparam int PW   = 24;
    localparam int DW   = 8;
    localparam int OC   = 10;
    localparam int NCH  = 6;
    localparam int AW_A = 32;
    localparam int AW_B = 25;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic in_valid;
    logic [OC*DW-1:0] bias_data;
    logic [OC*PW-1:0] in_data;

    always #5 clk = ~clk;

    classifier_head_if #(.PE_OUT_WIDTH(PW), .DATA_WIDTH(DW), .ACC_WIDTH(AW_A), .OUTPUT_CHANNEL(OC)) if_a ();
    classifier_head_if #(.PE_OUT_WIDTH(PW), .DATA_WIDTH(DW), .ACC_WIDTH(AW_B), .OUTPUT_CHANNEL(OC)) if_b ();

    assign if_a.start = start;
    assign if_a.bias_data = bias_data;
    assign if_a.in_valid = in_valid;
    assign if_a.in_data = in_data;
    assign if_b.start = start;
    assign if_b.bias_data = bias_data;
    assign if_b.in_valid = in_valid;
    assign if_b.in_data = in_data;

    classifier_head #(.PE_OUT_WIDTH(PW), .DATA_WIDTH(DW), .ACC_WIDTH(AW_A), .ARRAY_N(16),
                      .INP_CHANNEL(96), .OUTPUT_CHANNEL(OC)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    classifier_head #(.PE_OUT_WIDTH(PW), .DATA_WIDTH(DW), .ACC_WIDTH(AW_B), .ARRAY_N(16),
                      .INP_CHANNEL(96), .OUTPUT_CHANNEL(OC)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

    int compared = 0;
    int mismatched = 0;
    logic [PW-1:0] beat_lane [NCH][OC];
    logic [DW-1:0] bias_lane [OC];
    logic signed [63:0] last_max_a, last_max_b;
    logic signed [63:0] last_num_a, last_num_b;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: saturating accumulate of every beat, add bias, pick first maximum.
    function automatic void model(input int aw, output logic signed [63:0] best, output int idx);
        longint hi, lo, v;
        longint acc [OC];
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (aw - 1));
        for (int k = 0; k < OC; k++) begin
            acc[k] = 64'sd0;
            for (int b = 0; b < NCH; b++) begin
                v = acc[k] + longint'($signed(beat_lane[b][k]));
                acc[k] = (v > hi) ? hi : ((v < lo) ? lo : v);
            end
            v = acc[k] + longint'($signed(bias_lane[k]));
            acc[k] = (v > hi) ? hi : ((v < lo) ? lo : v);
        end
        best = acc[0];
        idx = 0;
        for (int k = 1; k < OC; k++) begin
            if (acc[k] > best) begin
                best = acc[k];
                idx = k;
            end
        end
    endfunction

    function automatic logic [OC*PW-1:0] pack_beat(input int b);
        logic [OC*PW-1:0] r;
        for (int k = 0; k < OC; k++) r[k*PW +: PW] = beat_lane[b][k];
        return r;
    endfunction

    function automatic logic [OC*DW-1:0] pack_bias();
        logic [OC*DW-1:0] r;
        for (int k = 0; k < OC; k++) r[k*DW +: DW] = bias_lane[k];
        return r;
    endfunction

    task automatic fill(input logic [PW-1:0] other, input int lane, input logic [PW-1:0] special,
                        input logic [DW-1:0] bias_val);
        for (int b = 0; b < NCH; b++)
            for (int k = 0; k < OC; k++) beat_lane[b][k] = (k == lane) ? special : other;
        for (int k = 0; k < OC; k++) bias_lane[k] = bias_val;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " in_ready"}, 64'(if_a.in_ready), 64'sd0);
        check({tag, " busy"}, 64'(if_a.busy), 64'sd0);
        check({tag, " done"}, 64'(if_a.done), 64'sd0);
        check({tag, " number"}, 64'(if_a.number), 64'sd0);
        check({tag, " max_val"}, if_a.max_val, 64'sd0);
        check({tag, " max_val_b"}, if_b.max_val, 64'sd0);
    endtask

    // stall_mode: 0 none, 1 alternate, 2 random. reset_after >= 0 aborts with reset after that many beats.
    task automatic run(input string name, input int stall_mode, input bit start_mid, input int reset_after);
        logic signed [63:0] exp_a, exp_b;
        int idx_a, idx_b, beats, cyc;
        bit stall, seen;
        model(AW_A, exp_a, idx_a);
        model(AW_B, exp_b, idx_b);
        @(negedge clk);
        bias_data = pack_bias();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " busy after start"}, 64'(if_a.busy), 64'sd1);
        check({name, " in_ready after start"}, 64'(if_b.in_ready), 64'sd1);
        beats = 0;
        cyc = 0;
        while (beats < NCH && cyc < 200) begin
            stall = (stall_mode == 1 && cyc % 2 == 1) || (stall_mode == 2 && $urandom_range(0, 2) == 0);
            in_valid = !stall;
            in_data = stall ? {OC*PW{1'b1}} : pack_beat(beats);
            start = start_mid && (cyc == 2);
            @(negedge clk);
            if (!stall) beats++;
            cyc++;
            if (reset_after >= 0 && beats == reset_after) begin
                in_valid = 1'b0;
                start = 1'b0;
                reset_n = 1'b0;
                #1;
                check_idle_zero({name, " async reset"});
                @(negedge clk);
                reset_n = 1'b1;
                repeat (20) @(negedge clk);
                check({name, " no done after reset"}, 64'(if_a.done), 64'sd0);
                check({name, " idle after reset"}, 64'(if_a.busy), 64'sd0);
                check({name, " number after reset"}, 64'(if_b.number), 64'sd0);
                return;
            end
        end
        start = 1'b0;
        check({name, " beat budget"}, 64'(beats), 64'(NCH));
        // Beats offered outside ACCUM must be ignored.
        in_valid = 1'b1;
        in_data = {OC*PW{1'b1}};
        check({name, " in_ready after last beat"}, 64'(if_a.in_ready), 64'sd0);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_a.done) seen = 1'b1;
        end
        check({name, " done latency"}, 64'(cyc), 64'sd11);
        check({name, " done_b"}, 64'(if_b.done), 64'sd1);
        check({name, " number_a"}, 64'(if_a.number), 64'(idx_a));
        check({name, " max_val_a"}, if_a.max_val, exp_a);
        check({name, " number_b"}, 64'(if_b.number), 64'(idx_b));
        check({name, " max_val_b"}, if_b.max_val, exp_b);
        last_num_a = 64'(if_a.number);
        last_max_a = if_a.max_val;
        last_num_b = 64'(if_b.number);
        last_max_b = if_b.max_val;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, " done one cycle"}, 64'(if_a.done), 64'sd0);
        check({name, " busy falls"}, 64'(if_a.busy), 64'sd0);
        check({name, " number held"}, 64'(if_a.number), 64'(idx_a));
        check({name, " max_val held"}, if_b.max_val, exp_b);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        bias_data = '0;
        in_data = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("idle after reset release");

        fill(24'd10, 7, 24'd100, 8'd0);
        run("lane7", 0, 1'b0, -1);
        check("lane7 number const", last_num_a, 64'sd7);
        check("lane7 max const", last_max_a, 64'sd600);

        fill(24'd1, 2, 24'd83, 8'd0);
        for (int b = 0; b < NCH; b++) beat_lane[b][5] = (b < 4) ? 24'd83 : 24'd84;
        beat_lane[4][2] = 24'd84;
        beat_lane[5][2] = 24'd84;
        run("tie", 0, 1'b0, -1);
        check("tie number const", last_num_a, 64'sd2);

        fill(24'd0, 0, 24'd0, 8'hFF);
        bias_lane[9] = 8'sh05;
        run("bias", 0, 1'b0, -1);
        check("bias number const", last_num_a, 64'sd9);
        check("bias max const", last_max_a, 64'sd5);

        fill(24'd0, 0, 24'h7FFFFF, 8'd0);
        run("sat_pos", 0, 1'b0, -1);
        check("sat_pos max25 const", last_max_b, 64'sd16777215);
        check("sat_pos max32 const", last_max_a, 64'sd50331642);

        fill(24'h800000, 0, 24'h800000, 8'd0);
        run("sat_neg", 0, 1'b0, -1);
        check("sat_neg max25 const", last_max_b, -64'sd16777216);
        check("sat_neg number const", last_num_b, 64'sd0);

        fill(24'd10, 7, 24'd100, 8'd0);
        run("stall_start", 1, 1'b1, -1);
        check("stall number const", last_num_a, 64'sd7);
        check("stall max const", last_max_a, 64'sd600);

        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < NCH; b++)
                for (int k = 0; k < OC; k++)
                    beat_lane[b][k] = (r % 2 == 0) ? (PW'($urandom_range(0, 2000)) - 24'd1000) : PW'($urandom);
            for (int k = 0; k < OC; k++) bias_lane[k] = DW'($urandom);
            run($sformatf("rand%0d", r), 2, r[0], -1);
        end

        fill(24'd5, 3, 24'd50, 8'd0);
        run("reset_mid", 0, 1'b0, 3);
        for (int b = 0; b < NCH; b++)
            for (int k = 0; k < OC; k++) beat_lane[b][k] = PW'($urandom_range(0, 4000)) - 24'd2000;
        for (int k = 0; k < OC; k++) bias_lane[k] = DW'($urandom);
        run("after_reset", 2, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/classifier_head.md
# classifier_head

Parametrised output stage of the PE-array accelerator. It accumulates per-output-channel partial sums streamed from the PE array across all input-channel chunks, adds a signed bias, and then scans the results sequentially to produce the winning class index (`number`) and its score. It sits between the PE array output and the top-level `number` port, and it generalises the fixed 96-channel, 10-class, 24-bit datapath to any channel count, class count and width.

## Interface
- `PE_OUT_WIDTH`, 24, signed width of each partial-sum lane.
- `DATA_WIDTH`, 8, signed width of each bias lane.
- `ACC_WIDTH`, 32, signed accumulator width; must be ≥ PE_OUT_WIDTH+1.
- `ARRAY_N`, 16, input channels consumed per partial-sum beat.
- `INP_CHANNEL`, 96, total input channels; must be a multiple of ARRAY_N.
- `OUTPUT_CHANNEL`, 10, number of classes; must be ≥ 2.
- Derived: `NUM_CHUNKS` = INP_CHANNEL/ARRAY_N (6). `IDX_W` = $clog2(OUTPUT_CHANNEL) (4).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a classification; honoured only in IDLE.
- `bias_data`  in  OUTPUT_CHANNEL*DATA_WIDTH  signed bias; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH]; sampled on the accepted `start`.
- `in_valid`  in  1  partial-sum beat present.
- `in_ready`  out  1  block accepts a beat; high only in ACCUM.
- `in_data`  in  OUTPUT_CHANNEL*PE_OUT_WIDTH  one signed partial sum per class; lanes packed like `bias_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the result is valid.
- `number`  out  IDX_W  winning class index; held until the next `done`.
- `max_val`  out  ACC_WIDTH  signed score of the winner; held with `number`.

## Operation
- States: IDLE → ACCUM → BIAS → SCAN → DONE → IDLE.
- IDLE: `start`=1 clears all accumulators, latches the bias lanes, clears the beat counter, and moves to ACCUM.
- ACCUM: `in_ready`=1. Each beat with `in_valid`&&`in_ready` adds the sign-extended lane k to acc[k].
  - The add saturates to the signed ACC_WIDTH range: max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1).
  - The beat counter increments on each accepted beat. On the NUM_CHUNKS-th accepted beat, go to BIAS.
  - A cycle with `in_valid`=0 stalls; nothing changes.
- BIAS (1 cycle): every acc[k] += sign-extended bias[k], saturating. Load best=acc[0]+bias[0] (saturated) and best_idx=0. Set scan index i=1.
- SCAN (OUTPUT_CHANNEL-1 cycles): if acc[i] > best (signed, strict), then best=acc[i] and best_idx=i. Increment i. After i=OUTPUT_CHANNEL-1, go to DONE.
- Ties: the lowest index wins.
- DONE (1 cycle): `done`=1, `number`=best_idx, `max_val`=best. Next state is IDLE.
- `start` outside IDLE is ignored. `in_valid` outside ACCUM is ignored, and no beat is consumed.
- Reset at any time: every state, counter and output returns to its reset value immediately (asynchronously). An in-flight classification is discarded and no `done` is produced for it.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `number`=0, `max_val`=0. Accumulators, counters and best are 0. State is IDLE.
- `start` sampled at edge S: `busy` and `in_ready` are high from S onward.
- Last beat accepted at edge E: BIAS occupies the cycle after E, and SCAN runs OUTPUT_CHANNEL-1 cycles after that. `done` is high for exactly one cycle, beginning at edge E+OUTPUT_CHANNEL+1 (edge E+11 at the defaults).
- `number`/`max_val` update at the same edge `done` rises and are stable until the next `done`.
- `busy` falls at the edge after `done`. `start` may be accepted on that same following edge.
- Minimum start-to-done time with no stalls: NUM_CHUNKS+OUTPUT_CHANNEL+1 cycles (17 at the defaults).

## Test plan
- Defaults; bias all 0; 6 beats, each with lane 7 = 100 and every other lane = 10 -> `done` pulse 11 cycles after the last beat, `number`=7, `max_val`=600.
- Tie: lanes 2 and 5 each sum to 500 with all other lanes lower, bias 0 -> `number`=2.
- Bias decides: all lanes sum to 0; bias lane 9 = 8'sh05, all others 8'shFF (-1) -> `number`=9, `max_val`=5.
- Saturation: ACC_WIDTH=25; lane 0 = 24'h7FFFFF on every beat -> acc[0] clamps to 2^24-1, `max_val`=16777215. Repeat with all lanes most-negative -> `max_val`=-2^24, `number`=0.
- Stalls and handshake: `in_valid` toggles 1/0 across 6 beats; `start` pulsed mid-ACCUM -> exactly 6 beats consumed, the `start` is ignored, and the result equals the no-stall result.
- Reset mid-operation: assert `reset_n`=0 after 3 beats -> all outputs 0 at once with no `done`. A fresh run then produces the correct, independent result.
